registro_word: RTL and testbench



---
 rtl/registro_word_if.sv | 19 +
 rtl/registro_word.sv | 46 ++++
 tb/tb_registro_word.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/registro_word_if.sv
// Bus bundle for registro_word: load enable, data in, registered data out and load pulse.
// With REGISTRO_PARITY_EN defined the bundle also carries the registered parity bit par.
interface registro_word_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] ent;
    logic [WIDTH-1:0] sal;
    logic             upd;
`ifdef REGISTRO_PARITY_EN
    logic             par;

    modport master (output en, ent, input sal, upd, par);
    modport slave  (input en, ent, output sal, upd, par);
`else
    modport master (output en, ent, input sal, upd);
    modport slave  (input en, ent, output sal, upd);
`endif
endinterface

// File: rtl/registro_word.sv
// Parameterised word register with load enable and a one-cycle load pulse.
// Optional macro REGISTRO_PARITY_EN adds a registered even-parity output par.
module registro_word #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [63:0] RST_VAL = 64'h0
) (
    input logic            clk,
    input logic            rst_n,
    registro_word_if.slave bus
);
    // RST_VAL is declared 64 bits wide so any legal WIDTH can take its low bits.
    localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] sal_q;
    logic             upd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sal_q <= RST_W;
            upd_q <= 1'b0;
        end else begin
            upd_q <= bus.en;
            if (bus.en) begin
                sal_q <= bus.ent;
            end
        end
    end

    assign bus.sal = sal_q;
    assign bus.upd = upd_q;

`ifdef REGISTRO_PARITY_EN
    // Parity is computed from the incoming word so it lands in the same cycle as sal.
    logic par_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= ^RST_W;
        end else if (bus.en) begin
            par_q <= ^bus.ent;
        end
    end

    assign bus.par = par_q;
`endif
endmodule

// File: tb/tb_registro_word.sv
// Table-driven bench for registro_word: three instances (zero reset, patterned reset, 8-bit truncated reset).
module tb_registro_word;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] ent;

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        en;
        logic [31:0] ent;
        logic [31:0] exp_sal_a;
        logic [31:0] exp_sal_b;
        logic        exp_upd;
        logic        exp_par;
    } vec_t;

    vec_t vecs[15];

    registro_word_if #(.WIDTH(32)) if_a ();
    registro_word_if #(.WIDTH(32)) if_b ();
    registro_word_if #(.WIDTH(8))  if_c ();

    assign if_a.en  = en;
    assign if_a.ent = ent;
    assign if_b.en  = en;
    assign if_b.ent = ent;
    assign if_c.en  = en;
    assign if_c.ent = ent[7:0];

    registro_word #(.WIDTH(32), .RST_VAL(64'h0)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_a)
    );

    registro_word #(.WIDTH(32), .RST_VAL(64'h5A5A5A5A)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_b)
    );

    // Reset value wider than WIDTH: only 0xCD should survive.
    registro_word #(.WIDTH(8), .RST_VAL(64'hABCD)) dut_c (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic r, input logic e, input logic [31:0] d);
        @(negedge clk);
        rst_n = r;
        en    = e;
        ent   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        ent      = 32'h0;

        vecs[0]  = '{"reset_1",        1'b0, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'h5A5A5A5A, 1'b0, 1'b0};
        vecs[1]  = '{"reset_2",        1'b0, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'h5A5A5A5A, 1'b0, 1'b0};
        vecs[2]  = '{"load_12",        1'b1, 1'b1, 32'h00000012, 32'h00000012, 32'h00000012, 1'b1, 1'b0};
        vecs[3]  = '{"load_ff",        1'b1, 1'b1, 32'h000000FF, 32'h000000FF, 32'h000000FF, 1'b1, 1'b0};
        vecs[4]  = '{"hold_51",        1'b1, 1'b0, 32'h00000051, 32'h000000FF, 32'h000000FF, 1'b0, 1'b0};
        vecs[5]  = '{"hold_30",        1'b1, 1'b0, 32'h00000030, 32'h000000FF, 32'h000000FF, 1'b0, 1'b0};
        vecs[6]  = '{"reenable_08",    1'b1, 1'b1, 32'h00000008, 32'h00000008, 32'h00000008, 1'b1, 1'b1};
        vecs[7]  = '{"disable_08",     1'b1, 1'b0, 32'h00000008, 32'h00000008, 32'h00000008, 1'b0, 1'b1};
        vecs[8]  = '{"reset_priority", 1'b0, 1'b1, 32'h000000AB, 32'h00000000, 32'h5A5A5A5A, 1'b0, 1'b0};
        vecs[9]  = '{"load_07",        1'b1, 1'b1, 32'h00000007, 32'h00000007, 32'h00000007, 1'b1, 1'b1};
        vecs[10] = '{"load_03",        1'b1, 1'b1, 32'h00000003, 32'h00000003, 32'h00000003, 1'b1, 1'b0};
        vecs[11] = '{"hold_01",        1'b1, 1'b0, 32'h00000001, 32'h00000003, 32'h00000003, 1'b0, 1'b0};
        vecs[12] = '{"load_same_03",   1'b1, 1'b1, 32'h00000003, 32'h00000003, 32'h00000003, 1'b1, 1'b0};
        vecs[13] = '{"load_deadbeef",  1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[14] = '{"hold_00",        1'b1, 1'b0, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].ent);
            checkOutput({vecs[i].name, "_sal_a"}, 64'(if_a.sal), 64'(vecs[i].exp_sal_a));
            checkOutput({vecs[i].name, "_sal_b"}, 64'(if_b.sal), 64'(vecs[i].exp_sal_b));
            checkOutput({vecs[i].name, "_upd_a"}, 64'(if_a.upd), 64'(vecs[i].exp_upd));
            checkOutput({vecs[i].name, "_upd_b"}, 64'(if_b.upd), 64'(vecs[i].exp_upd));
`ifdef REGISTRO_PARITY_EN
            checkOutput({vecs[i].name, "_par_a"}, 64'(if_a.par), 64'(vecs[i].exp_par));
            checkOutput({vecs[i].name, "_par_b"}, 64'(if_b.par), 64'(vecs[i].exp_par));
`endif
        end

        // An enable pulse that rises and falls between edges must not load.
        @(negedge clk);
        en  = 1'b1;
        ent = 32'h00000077;
        #2;
        en  = 1'b0;
        ent = 32'h00000000;
        @(posedge clk);
        #1;
        checkOutput("glitch_sal_a", 64'(if_a.sal), 64'hDEADBEEF);
        checkOutput("glitch_upd_a", 64'(if_a.upd), 64'h0);

        applyStimulus(1'b0, 1'b1, 32'h000001A5);
        checkOutput("narrow_reset_sal_c", 64'(if_c.sal), 64'hCD);
        checkOutput("narrow_reset_upd_c", 64'(if_c.upd), 64'h0);
`ifdef REGISTRO_PARITY_EN
        checkOutput("narrow_reset_par_c", 64'(if_c.par), 64'h1);
`endif

        applyStimulus(1'b1, 1'b1, 32'h000001A5);
        checkOutput("narrow_load_sal_c", 64'(if_c.sal), 64'hA5);
        checkOutput("narrow_load_upd_c", 64'(if_c.upd), 64'h1);
        checkOutput("wide_load_sal_a",   64'(if_a.sal), 64'h1A5);

        applyStimulus(1'b1, 1'b0, 32'h0000005C);
        checkOutput("narrow_hold_sal_c", 64'(if_c.sal), 64'hA5);
        checkOutput("narrow_hold_upd_c", 64'(if_c.upd), 64'h0);

        // Two back-to-back loads keep upd high across both cycles.
        applyStimulus(1'b1, 1'b1, 32'h11111111);
        checkOutput("burst1_upd_a", 64'(if_a.upd), 64'h1);
        applyStimulus(1'b1, 1'b1, 32'h22222222);
        checkOutput("burst2_upd_a", 64'(if_a.upd), 64'h1);
        checkOutput("burst2_sal_a", 64'(if_a.sal), 64'h22222222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
